csla_64_bist: RTL and testbench

//  Self-test controller for the 64-bit carry-select adder (csla_64): acts as the consuming/checking end of the adder

---
 rtl/csla_pkg.sv | 55 +++++
 rtl/csla_64_bist_lfsr64.sv | 26 ++
 rtl/csla_64_bist.sv | 150 +++++++++++++++
 tb/tb_csla_64_bist.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/csla_pkg.sv
// Shared definitions for the csla_64 self-test controller: FSM states,
// directed vector table, LFSR feedback polynomial and the "no failure" index.
package csla_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIRECTED = 3'd1,
    RANDOM   = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
  } vec_t;

  localparam logic [15:0] NONE_IDX          = 16'hFFFF;
  localparam logic [15:0] LAST_DIRECTED_IDX = 16'd7;
  localparam int          NUM_DIRECTED      = 8;

  // x^64 + x^63 + x^61 + x^60 + 1, right-shifting Galois form
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // One Galois LFSR step: shift right, fold the taps back in when bit 0 falls out
  function automatic logic [63:0] lfsr_next(input logic [63:0] cur);
    logic [63:0] nxt;
    nxt = {1'b0, cur[63:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Directed vector table: hand-picked carry-chain corner cases
  function automatic vec_t directed_vec(input logic [2:0] idx);
    vec_t v;
    case (idx)
      3'd0:    v = '{a: 64'd0,          b: 64'd0,              cin: 1'b0};
      3'd1:    v = '{a: 64'd2,          b: 64'd2,              cin: 1'b1};
      3'd2:    v = '{a: 64'd2,          b: 64'd4,              cin: 1'b1};
      3'd3:    v = '{a: 64'd100,        b: 64'd0,              cin: 1'b0};
      3'd4:    v = '{a: 64'd1234567890, b: 64'd11111111111111, cin: 1'b1};
      3'd5:    v = '{a: 64'd1234567890, b: 64'd111123452,      cin: 1'b1};
      3'd6:    v = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd0,     cin: 1'b1};
      3'd7:    v = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, cin: 1'b1};
      default: v = '{a: 64'd0,          b: 64'd0,              cin: 1'b0};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/csla_64_bist_lfsr64.sv
// 64-bit Galois LFSR with seed reload; used for the pseudo-random operands.
module lfsr64
  import csla_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] q
);

  // Seed on reset or load, otherwise advance one step per request
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/csla_64_bist.sv
// Self-test controller for csla_64: drives directed then pseudo-random
// vectors into the adder, checks {cout,sum} against a behavioural adder and
// records the number of mismatches and the index of the first one.
module csla_64_bist
  import csla_pkg::*;
#(
  parameter int          WIDTH      = 64,
  parameter int          NUM_RANDOM = 256,
  parameter logic [63:0] SEED_A     = 64'hACE1_2468_1357_BDF0,
  parameter logic [63:0] SEED_B     = 64'h0F1E_2D3C_4B5A_6978
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_fail_idx
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_DIRECTED + NUM_RANDOM - 1);

  state_t         state;
  logic [15:0]    idx;
  logic [15:0]    cmp_idx;
  logic           cmp_valid;
  logic           start_ok;
  logic           lfsr_step;
  logic [63:0]    lfsr_a_q;
  logic [63:0]    lfsr_b_q;
  vec_t           dir_vec;
  logic [WIDTH:0] golden;
  logic [WIDTH:0] observed;
  logic           mismatch;

  // A run may only be launched from an idle or finished controller
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign lfsr_step = (state == RANDOM);
  assign dir_vec   = directed_vec(idx[2:0]);

  // Golden model works on the held operand registers, one bit wider than the adder
  assign golden   = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign observed = {dut_cout, dut_sum};
  assign mismatch = cmp_valid && (observed != golden);

  lfsr64 u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .seed (SEED_A),
    .step (lfsr_step),
    .q    (lfsr_a_q)
  );

  lfsr64 u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .seed (SEED_B),
    .step (lfsr_step),
    .q    (lfsr_b_q)
  );

  // Controller FSM: vector sequencing, one compare per applied vector, status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 16'd0;
      cmp_idx        <= 16'd0;
      cmp_valid      <= 1'b0;
      dut_a          <= {WIDTH{1'b0}};
      dut_b          <= {WIDTH{1'b0}};
      dut_cin        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'd0;
      first_fail_idx <= NONE_IDX;
    end else begin
      // Vector applied on the previous edge is checked now
      if (mismatch) begin
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
        if (first_fail_idx == NONE_IDX) begin
          first_fail_idx <= cmp_idx;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= DIRECTED;
            idx            <= 16'd0;
            cmp_valid      <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_fail_idx <= NONE_IDX;
          end
        end
        DIRECTED: begin
          dut_a     <= WIDTH'(dir_vec.a);
          dut_b     <= WIDTH'(dir_vec.b);
          dut_cin   <= dir_vec.cin;
          cmp_valid <= 1'b1;
          cmp_idx   <= idx;
          busy      <= 1'b1;
          idx       <= idx + 16'd1;
          if (idx == LAST_DIRECTED_IDX) begin
            state <= (NUM_RANDOM == 0) ? CHECK : RANDOM;
          end
        end
        RANDOM: begin
          dut_a     <= WIDTH'(lfsr_a_q);
          dut_b     <= WIDTH'(lfsr_b_q);
          dut_cin   <= lfsr_a_q[0] ^ lfsr_b_q[63];
          cmp_valid <= 1'b1;
          cmp_idx   <= idx;
          busy      <= 1'b1;
          idx       <= idx + 16'd1;
          if (idx == LAST_IDX) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          // First CHECK edge compares the last vector; the next one publishes the result
          if (cmp_valid) begin
            cmp_valid <= 1'b0;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csla_64_bist.sv
// Directed bench for csla_64_bist: plays the adder (with optional faults),
// checks reset, vector sequencing, fault detection, restart and rst mid-run.
module tb_csla_64_bist;

  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SEED_A = 64'hACE1_2468_1357_BDF0;
  localparam logic [63:0] SEED_B = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0] TAPS   = 64'hD800_0000_0000_0000;
  localparam int          T      = 264;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  int          fault_mode = 0;

  logic [63:0] dut_a, dut_b, dut_sum;
  logic        dut_cin, dut_cout, busy, done, pass;
  logic [15:0] err_count, first_fail_idx;
  logic [64:0] full;

  logic [63:0] a0, b0, sum0;
  logic        cin0, cout0, busy0, done0, pass0;
  logic [15:0] err0, ffi0;
  logic [64:0] full0;

  int          checks = 0;
  int          errors = 0;

  logic [63:0] exp_a [8];
  logic [63:0] exp_b [8];
  logic        exp_c [8];
  logic [63:0] m_a, m_b, last_a, last_b;
  logic        m_cin;
  logic [64:0] m_full;
  int          carry_cnt;

  always #5 clk = ~clk;

  csla_64_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  csla_64_bist #(.NUM_RANDOM(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_cin(cin0),
    .dut_sum(sum0), .dut_cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_idx(ffi0)
  );

  // Adder stand-in with selectable faults
  always_comb begin
    full = {1'b0, dut_a} + {1'b0, dut_b} + {64'd0, dut_cin};
    if (fault_mode == 1 && dut_a == 64'd100) full[0] = ~full[0];
    else if (fault_mode == 2) full[64] = 1'b0;
  end
  assign dut_sum  = full[63:0];
  assign dut_cout = full[64];

  // Clean adder for the NUM_RANDOM=0 instance
  always_comb full0 = {1'b0, a0} + {1'b0, b0} + {64'd0, cin0};
  assign sum0  = full0[63:0];
  assign cout0 = full0[64];

  function automatic logic [63:0] galois(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    exp_a[0] = 64'd0;          exp_b[0] = 64'd0;              exp_c[0] = 1'b0;
    exp_a[1] = 64'd2;          exp_b[1] = 64'd2;              exp_c[1] = 1'b1;
    exp_a[2] = 64'd2;          exp_b[2] = 64'd4;              exp_c[2] = 1'b1;
    exp_a[3] = 64'd100;        exp_b[3] = 64'd0;              exp_c[3] = 1'b0;
    exp_a[4] = 64'd1234567890; exp_b[4] = 64'd11111111111111; exp_c[4] = 1'b1;
    exp_a[5] = 64'd1234567890; exp_b[5] = 64'd111123452;      exp_c[5] = 1'b1;
    exp_a[6] = ONES;           exp_b[6] = 64'd0;              exp_c[6] = 1'b1;
    exp_a[7] = ONES;           exp_b[7] = ONES;               exp_c[7] = 1'b1;

    // Reference model of the random phase: carry-outs and the final vector
    m_a = SEED_A; m_b = SEED_B; carry_cnt = 0; last_a = 64'd0; last_b = 64'd0;
    for (int i = 0; i < 256; i++) begin
      m_cin  = m_a[0] ^ m_b[63];
      m_full = {1'b0, m_a} + {1'b0, m_b} + {64'd0, m_cin};
      if (m_full[64]) carry_cnt++;
      last_a = m_a; last_b = m_b;
      m_a = galois(m_a); m_b = galois(m_b);
    end

    // Reset state
    tick(2);
    rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pass", {63'd0, pass}, 64'd0);
    chk("rst_err",  {48'd0, err_count}, 64'd0);
    chk("rst_ffi",  {48'd0, first_fail_idx}, 64'hFFFF);
    chk("rst_a",    dut_a, 64'd0);

    // Run 1: clean adder, vector sequencing and ignored restart
    pulse_start();                                  // edge E
    chk("busy_at_E", {63'd0, busy}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick(1);                                      // after E+1+k
      chk($sformatf("dir%0d_a", k), dut_a, exp_a[k]);
      chk($sformatf("dir%0d_b", k), dut_b, exp_b[k]);
      chk($sformatf("dir%0d_cin", k), {63'd0, dut_cin}, {63'd0, exp_c[k]});
    end
    chk("busy_run", {63'd0, busy}, 64'd1);
    tick(1);                                        // E+9: first random vector
    chk("rnd0_a", dut_a, SEED_A);
    chk("rnd0_b", dut_b, SEED_B);
    chk("rnd0_cin", {63'd0, dut_cin}, {63'd0, SEED_A[0] ^ SEED_B[63]});
    tick(1);                                        // E+10
    chk("rnd1_a", dut_a, galois(SEED_A));
    chk("rnd1_b", dut_b, galois(SEED_B));
    tick(9);                                        // E+19
    pulse_start();                                  // E+20, ignored
    chk("restart_busy", {63'd0, busy}, 64'd1);
    tick(T + 1 - 20);                               // E+T+1
    chk("pre_done", {63'd0, done}, 64'd0);
    chk("pre_done_busy", {63'd0, busy}, 64'd1);
    tick(1);                                        // E+T+2
    chk("r1_done", {63'd0, done}, 64'd1);
    chk("r1_busy", {63'd0, busy}, 64'd0);
    chk("r1_pass", {63'd0, pass}, 64'd1);
    chk("r1_err",  {48'd0, err_count}, 64'd0);
    chk("r1_ffi",  {48'd0, first_fail_idx}, 64'hFFFF);
    chk("r1_hold_a", dut_a, last_a);
    chk("r1_hold_b", dut_b, last_b);

    // Run 2: sum[0] flipped when a==100
    fault_mode = 1;
    pulse_start();
    tick(1);
    chk("r2_done_clr", {63'd0, done}, 64'd0);
    tick(T + 1);
    chk("r2_done", {63'd0, done}, 64'd1);
    chk("r2_err",  {48'd0, err_count}, 64'd1);
    chk("r2_ffi",  {48'd0, first_fail_idx}, 64'd3);
    chk("r2_pass", {63'd0, pass}, 64'd0);

    // Run 3: cout stuck at 0
    fault_mode = 2;
    pulse_start();
    tick(1);
    chk("r3_err_clr", {48'd0, err_count}, 64'd0);
    chk("r3_ffi_clr", {48'd0, first_fail_idx}, 64'hFFFF);
    tick(T + 1);
    chk("r3_done", {63'd0, done}, 64'd1);
    chk("r3_err",  {48'd0, err_count}, 64'(2 + carry_cnt));
    chk("r3_ffi",  {48'd0, first_fail_idx}, 64'd6);
    chk("r3_pass", {63'd0, pass}, 64'd0);

    // Run 4: rst mid-run, then a clean rerun
    fault_mode = 0;
    pulse_start();
    tick(49);
    rst = 1'b1;
    tick(1);                                        // edge E+50
    rst = 1'b0;
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, done}, 64'd0);
    chk("mrst_err",  {48'd0, err_count}, 64'd0);
    chk("mrst_ffi",  {48'd0, first_fail_idx}, 64'hFFFF);
    chk("mrst_a",    dut_a, 64'd0);
    tick(3);
    chk("mrst_idle", {63'd0, busy}, 64'd0);
    pulse_start();
    tick(T + 2);
    chk("r5_done", {63'd0, done}, 64'd1);
    chk("r5_pass", {63'd0, pass}, 64'd1);
    chk("r5_a", dut_a, last_a);

    // NUM_RANDOM=0 instance: directed set only
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(9);                                        // E+10 reached after next tick
    chk("nr0_pre_done", {63'd0, done0}, 64'd0);
    tick(1);
    chk("nr0_done", {63'd0, done0}, 64'd1);
    chk("nr0_pass", {63'd0, pass0}, 64'd1);
    chk("nr0_ffi",  {48'd0, ffi0}, 64'hFFFF);
    chk("nr0_a", a0, ONES);
    chk("nr0_b", b0, ONES);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
